// File: rtl/eth_pkg.sv
// Shared Ethernet receive types and constants for the rx frame filter.
package eth_pkg;
   typedef logic [47:0] mac_addr_t;

   localparam int        HDR_LEN   = 6;
   localparam mac_addr_t BCAST_MAC = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {IDLE, HDR, FWD, DROP, FLUSH} filt_state_t;
endpackage

// File: rtl/rx_frame_filter_if.sv
// Byte stream with frame delimiter; used for both the MAC input and the filtered output.
interface rx_frame_filter_if;
   logic [7:0] data;
   logic       valid;
   logic       last;

   modport master (output data, valid, last);
   modport slave  (input  data, valid, last);
endinterface

// File: rtl/hdr_delay_line.sv
// Byte delay line with fill count: shift-in on push, pop-oldest, parallel header read.
// o_hdr_next is the header as it stands once i_dat is shifted in (oldest byte in the MSBs).
module hdr_delay_line #(
   parameter int DEPTH = 6
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clr,
   input  logic                       i_push,
   input  logic [7:0]                 i_dat,
   input  logic                       i_pop,
   output logic [$clog2(DEPTH+1)-1:0] o_fill,
   output logic [7:0]                 o_oldest,
   output logic [8*DEPTH-1:0]         o_hdr_next
);
   localparam int FILL_W = $clog2(DEPTH+1);

   logic [8*DEPTH-1:0] r_buf;
   logic [FILL_W-1:0]  r_fill;
   logic [7:0]         w_oldest;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_buf  <= '0;
         r_fill <= '0;
      end else begin
         if (i_push)
            r_buf <= {r_buf[8*DEPTH-9:0], i_dat};
         if (i_clr)
            r_fill <= i_push ? FILL_W'(1) : '0;
         else if (i_push && !i_pop && r_fill != FILL_W'(DEPTH))
            r_fill <= r_fill + FILL_W'(1);
         else if (!i_push && i_pop && r_fill != '0)
            r_fill <= r_fill - FILL_W'(1);
      end
   end

   // Bytes shift toward the MSBs, so the oldest byte sits at index fill-1.
   always_comb begin
      w_oldest = '0;
      for (int i = 0; i < DEPTH; i++)
         if (r_fill == FILL_W'(i + 1))
            w_oldest = r_buf[8*i +: 8];
   end

   assign o_fill     = r_fill;
   assign o_oldest   = w_oldest;
   assign o_hdr_next = {r_buf[8*DEPTH-9:0], i_dat};
endmodule

// File: rtl/rx_frame_filter.sv
// Destination-MAC frame filter: forwards own/broadcast frames (all frames with RX_FILTER_PROMISC_EN),
// one-cycle registered output latency, fifo_full only gates the accept decision and sets overflow_err.
module rx_frame_filter
   import eth_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int LEN_W = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   rx_frame_filter_if.slave   i_rx,
   rx_frame_filter_if.master  o_out,
   input  mac_addr_t          i_own_mac,
   input  logic               i_fifo_full,
   output logic [LEN_W-1:0]   o_len_data,
   output logic               o_len_valid,
   output logic [CNT_W-1:0]   o_cnt_accept,
   output logic [CNT_W-1:0]   o_cnt_drop,
   output logic               o_overflow_err
);
   localparam int FILL_W = $clog2(HDR_LEN + 1);

   filt_state_t        r_state, w_state_nxt;
   logic [7:0]         r_out_data;
   logic               r_out_valid, r_out_last;
   logic [LEN_W-1:0]   r_len, r_len_data;
   logic               r_len_valid;
   logic [CNT_W-1:0]   r_cnt_accept, r_cnt_drop;
   logic               r_ovf, r_viol;

   logic               w_push, w_pop, w_clr, w_emit, w_final, w_drop_inc, w_len_clr, w_viol_nxt;
   logic               w_addr_ok;
   logic [FILL_W-1:0]  w_fill;
   logic [7:0]         w_oldest;
   mac_addr_t          w_dst;

   hdr_delay_line #(.DEPTH(HDR_LEN)) u_dly (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (w_clr),
      .i_push     (w_push),
      .i_dat      (i_rx.data),
      .i_pop      (w_pop),
      .o_fill     (w_fill),
      .o_oldest   (w_oldest),
      .o_hdr_next (w_dst)
   );

`ifdef RX_FILTER_PROMISC_EN
   assign w_addr_ok = 1'b1;
`else
   assign w_addr_ok = (w_dst == i_own_mac) || (w_dst == BCAST_MAC);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_clr       = 1'b0;
      w_emit      = 1'b0;
      w_final     = 1'b0;
      w_drop_inc  = 1'b0;
      w_len_clr   = 1'b0;
      w_viol_nxt  = r_viol;
      case (r_state)
         IDLE: begin
            w_clr = 1'b1;
            if (i_rx.valid) begin
               w_push = 1'b1;
               if (i_rx.last) w_drop_inc  = 1'b1;
               else           w_state_nxt = HDR;
            end
         end
         HDR: begin
            if (i_rx.valid) begin
               w_push = 1'b1;
               // A frame ending on or before the sixth byte is a runt.
               if (i_rx.last) begin
                  w_drop_inc  = 1'b1;
                  w_state_nxt = IDLE;
               end else if (w_fill == FILL_W'(HDR_LEN - 1)) begin
                  if (w_addr_ok && !i_fifo_full) begin
                     w_len_clr   = 1'b1;
                     w_state_nxt = FWD;
                  end else begin
                     w_drop_inc  = 1'b1;
                     w_state_nxt = DROP;
                  end
               end
            end
         end
         FWD: begin
            if (i_rx.valid) begin
               w_push = 1'b1;
               w_pop  = 1'b1;
               w_emit = 1'b1;
               if (i_rx.last) w_state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            w_pop  = 1'b1;
            w_emit = 1'b1;
            // Bytes arriving mid-flush break the IFG; their frame is counted and discarded once.
            if (i_rx.valid) begin
               if (!r_viol) w_drop_inc = 1'b1;
               w_viol_nxt = !i_rx.last;
            end
            if (w_fill == FILL_W'(1)) begin
               w_final     = 1'b1;
               w_state_nxt = w_viol_nxt ? DROP : IDLE;
            end
         end
         DROP: begin
            if (i_rx.valid && i_rx.last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_len        <= '0;
         r_len_data   <= '0;
         r_len_valid  <= 1'b0;
         r_cnt_accept <= '0;
         r_cnt_drop   <= '0;
         r_ovf        <= 1'b0;
         r_viol       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_emit;
         r_out_last  <= w_final;
         r_len_valid <= w_final;
         r_viol      <= w_final ? 1'b0 : w_viol_nxt;
         r_ovf       <= r_ovf | (r_out_valid & i_fifo_full);
         if (w_emit)
            r_out_data <= w_oldest;
         if (w_len_clr)
            r_len <= '0;
         else if (w_emit && !(&r_len))
            r_len <= r_len + LEN_W'(1);
         if (w_final) begin
            r_len_data <= (&r_len) ? r_len : r_len + LEN_W'(1);
            if (!(&r_cnt_accept)) r_cnt_accept <= r_cnt_accept + CNT_W'(1);
         end
         if (w_drop_inc && !(&r_cnt_drop))
            r_cnt_drop <= r_cnt_drop + CNT_W'(1);
      end
   end

   assign o_out.data     = r_out_data;
   assign o_out.valid    = r_out_valid;
   assign o_out.last     = r_out_last;
   assign o_len_data     = r_len_data;
   assign o_len_valid    = r_len_valid;
   assign o_cnt_accept   = r_cnt_accept;
   assign o_cnt_drop     = r_cnt_drop;
   assign o_overflow_err = r_ovf;
endmodule

// File: tb/tb_rx_frame_filter.sv
// Self-checking bench for rx_frame_filter: frame table plus reset and mid-flush corner sequences.
module tb_rx_frame_filter;
   import eth_pkg::*;

   localparam int        CNT_W = 16;
   localparam int        LEN_W = 16;
   localparam mac_addr_t OWN   = 48'h02_00_00_00_00_01;
   localparam mac_addr_t OTHER = 48'h02_00_00_00_00_02;

   logic             clk = 1'b0;
   logic             rst;
   mac_addr_t        own_mac;
   logic             fifo_full;
   logic [LEN_W-1:0] len_data;
   logic             len_valid;
   logic [CNT_W-1:0] cnt_accept, cnt_drop;
   logic             overflow_err;

   rx_frame_filter_if rx_if ();
   rx_frame_filter_if out_if ();

   always #5 clk = ~clk;

   rx_frame_filter #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_rx           (rx_if),
      .o_out          (out_if),
      .i_own_mac      (own_mac),
      .i_fifo_full    (fifo_full),
      .o_len_data     (len_data),
      .o_len_valid    (len_valid),
      .o_cnt_accept   (cnt_accept),
      .o_cnt_drop     (cnt_drop),
      .o_overflow_err (overflow_err)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] exp_q[$];
   int         len_q[$];
   int         m_acc, m_drop;

   typedef struct {
      mac_addr_t dst;
      int        len;
      int        full_byte;
      bit        full_gap;
      bit        exp_acc;
      bit        exp_ovf;
   } vec_t;
   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input mac_addr_t dst, input int i);
      mac_addr_t d;
      d = dst;
      if (i < 6) return d[8*(5-i) +: 8];
      return 8'(i * 3 + 1);
   endfunction

   task automatic send_byte(input logic [7:0] d, input bit l, input bit full_v, input bit full_g);
      @(posedge clk); #1;
      rx_if.valid = 1'b1;
      rx_if.data  = d;
      rx_if.last  = l;
      fifo_full   = full_v;
      @(posedge clk); #1;
      rx_if.valid = 1'b0;
      rx_if.last  = 1'b0;
      fifo_full   = full_g;
   endtask

   task automatic send_frame(input mac_addr_t dst, input int len, input int full_byte,
                             input bit full_gap, input bit acc);
      if (acc) begin
         for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), byte_at(dst, i)});
         len_q.push_back(len);
      end
      for (int i = 0; i < len; i++)
         send_byte(byte_at(dst, i), (i == len - 1), (i == full_byte) && !full_gap,
                   (i == full_byte) && full_gap);
   endtask

   task automatic drain(input string tag);
      @(posedge clk); #1;
      fifo_full = 1'b0;
      for (int i = 0; i < 100 && (exp_q.size() != 0 || len_q.size() != 0); i++) @(posedge clk);
      repeat (4) @(posedge clk);
      check({tag, "_bytes_left"}, exp_q.size(), 0);
      check({tag, "_lens_left"}, len_q.size(), 0);
   endtask

   task automatic check_counts(input string tag, input bit ovf);
      @(negedge clk);
      check({tag, "_cnt_accept"}, cnt_accept, m_acc);
      check({tag, "_cnt_drop"}, cnt_drop, m_drop);
      check({tag, "_overflow_err"}, overflow_err, ovf);
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      check({tag, "_out_valid"}, out_if.valid, 0);
      check({tag, "_out_last"}, out_if.last, 0);
      check({tag, "_out_data"}, out_if.data, 0);
      check({tag, "_len_valid"}, len_valid, 0);
      check({tag, "_len_data"}, len_data, 0);
      check({tag, "_cnt_accept"}, cnt_accept, 0);
      check({tag, "_cnt_drop"}, cnt_drop, 0);
      check({tag, "_overflow_err"}, overflow_err, 0);
   endtask

   // Output monitor: every forwarded byte and length is popped from the scoreboard.
   always @(negedge clk) begin : mon
      logic [8:0] e;
      if (!rst) begin
         if (out_if.valid) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", out_if.valid, 0);
            else begin
               e = exp_q.pop_front();
               check("out_data", out_if.data, e[7:0]);
               check("out_last", out_if.last, e[8]);
            end
         end
         if (len_valid) begin
            check("len_valid_with_last", out_if.valid && out_if.last, 1);
            if (len_q.size() == 0) check("unexpected_len_valid", len_valid, 0);
            else check("len_data", len_data, len_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      rx_if.valid = 1'b0;
      rx_if.data  = '0;
      rx_if.last  = 1'b0;
      fifo_full   = 1'b0;
      own_mac     = OWN;
      m_acc       = 0;
      m_drop      = 0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      check_zero("reset");

      //          dst                      len full_byte gap acc ovf
      vecs[0] = '{OWN,                     64, -1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{OTHER,                   64, -1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{BCAST_MAC,               60, -1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{OWN,                      5, -1, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{OWN,                      6, -1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{OWN,                      7, -1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{OWN,                     64,  5, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{OWN,                     64, 20, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{BCAST_MAC,                1, -1, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{48'h02_00_00_00_01_01,   64, -1, 1'b0, 1'b0, 1'b1};

      for (int k = 0; k < 10; k++) begin
         bit acc;
`ifdef RX_FILTER_PROMISC_EN
         acc = (vecs[k].len >= 7) && !(vecs[k].full_byte == 5 && !vecs[k].full_gap);
`else
         acc = vecs[k].exp_acc;
`endif
         send_frame(vecs[k].dst, vecs[k].len, vecs[k].full_byte, vecs[k].full_gap, acc);
         drain($sformatf("v%0d", k));
         if (acc) m_acc++;
         else     m_drop++;
         check_counts($sformatf("v%0d", k), vecs[k].exp_ovf);
      end

      // Next frame starts while the previous one is still flushing.
      send_frame(OWN, 10, -1, 1'b0, 1'b1);
      send_frame(OWN, 5, -1, 1'b0, 1'b0);
      drain("viol");
      m_acc++;
      m_drop++;
      check_counts("viol", 1'b1);
      send_frame(BCAST_MAC, 7, -1, 1'b0, 1'b1);
      drain("post_viol");
      m_acc++;
      check_counts("post_viol", 1'b1);

      // Reset after 20 forwarded bytes of a 100-byte frame.
      for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, byte_at(OWN, i)});
      for (int i = 0; i < 26; i++) send_byte(byte_at(OWN, i), 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("midrst");
      check("midrst_bytes_left", exp_q.size(), 0);
      exp_q.delete();
      len_q.delete();
      m_acc  = 0;
      m_drop = 0;
      for (int i = 26; i < 100; i++) send_byte(byte_at(OWN, i), (i == 99), 1'b0, 1'b0);
      drain("tail");
      m_drop++;
      check_counts("tail", 1'b0);
      send_frame(OWN, 64, -1, 1'b0, 1'b1);
      drain("after_rst");
      m_acc++;
      check_counts("after_rst", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rx_frame_filter.md
Name: rx_frame_filter

Overview:
- Sits between the MAC receive byte stream and the rx data/length FIFOs, in the rx_mac_clk domain.
- Inspects the 6-byte destination MAC of each frame. Forwards accepted frames (own address, broadcast) byte-for-byte; discards all others.
- On the last forwarded byte, emits the forwarded byte count for the length FIFO.
- Keeps saturating accept/drop statistics.

Parameters:
- HDR_LEN, 6: destination-address bytes buffered before the accept decision. Fixed by Ethernet; not to be overridden.
- CNT_W, 16: width of the statistics counters.
- LEN_W, 16: width of the frame-length output.

Ports:
- clk  in  1  rx_mac_clk domain clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from MAC
- rx_valid  in  1  rx_data valid this cycle
- rx_last  in  1  qualifies the final byte of a frame (valid only with rx_valid)
- own_mac  in  48  station address; first-received byte = own_mac[47:40]
- fifo_full  in  1  full flag of the downstream data FIFO
- out_data  out  8  forwarded byte
- out_valid  out  1  out_data valid (data FIFO write strobe)
- out_last  out  1  final forwarded byte of a frame
- len_data  out  LEN_W  bytes forwarded in the frame just completed
- len_valid  out  1  one-cycle pulse coincident with out_last
- cnt_accept  out  CNT_W  frames forwarded
- cnt_drop  out  CNT_W  frames discarded (address mismatch, runt, FIFO full)
- overflow_err  out  1  sticky: fifo_full seen while out_valid was high

Behaviour:
- Reset: every output is 0; the FSM enters IDLE; the delay line is cleared.
- Delay line: HDR_LEN x 8 shift register with a fill count (0..6), advanced only on rx_valid.
- FSM states: IDLE, HDR, FWD, DROP, FLUSH.
- IDLE:
  - rx_valid: shift the byte in, fill=1, go to HDR.
  - rx_valid with rx_last: runt frame; cnt_drop++, stay in IDLE.
- HDR:
  - Shift the byte in on each rx_valid.
  - rx_last before fill reaches 6: runt; cnt_drop++, go to IDLE.
  - On the beat that makes fill=6, decide. Accept if dst==own_mac or dst==48'hFFFF_FFFF_FFFF, and fifo_full==0 on that cycle.
  - Accept: go to FWD, length counter=0. Otherwise: cnt_drop++, go to DROP.
  - A 6-byte frame whose 6th byte carries rx_last is a runt: dropped.
- FWD:
  - Each rx_valid shifts the new byte in and registers the oldest byte out. out_valid asserts the cycle after rx_valid (1-cycle registered latency); the length counter increments.
  - On rx_last: go to FLUSH.
- FLUSH:
  - Emit the remaining 6 buffered bytes, one per clk, out_valid high each cycle.
  - On the final byte: out_last=1, len_valid=1, len_data=total bytes forwarded, cnt_accept++. Then go to IDLE with fill=0.
- DROP: ignore bytes until rx_valid with rx_last, then go to IDLE. No output activity.
- rx_valid during FLUSH is a protocol violation (Ethernet IFG guarantees ≥20 idle byte times). The byte is ignored and not forwarded; the frame it belongs to is dropped (FSM enters DROP after the flush), cnt_drop++.
- Length: forwarded bytes include FCS. len_data saturates at all-ones, and out_last is still issued.
- Counters saturate at 2^CNT_W-1; they never wrap.
- overflow_err: set when out_valid && fifo_full; cleared only by rst. Data is still presented when the flag sets; the FIFO discards it.
- rst mid-frame: the partially forwarded frame is abandoned with no out_last or len_valid. The next frame must begin from IDLE; the remaining bytes of the interrupted frame are treated as a new frame (typically dropped by address mismatch).

Optional Feature:
- Macro RX_FILTER_PROMISC_EN.
- Defined: the address check is bypassed. Every frame ≥7 bytes is accepted, provided fifo_full==0 at the decision beat. Runt and FIFO-full drops still apply.
- Undefined: only own_mac and broadcast frames are accepted, as above.

Decomposition:
- Package eth_pkg:
  - mac_addr_t (logic [47:0])
  - BCAST_MAC constant
  - HDR_LEN constant
  - enum filt_state_t {IDLE, HDR, FWD, DROP, FLUSH}
- Sub-module hdr_delay_line:
  - Parameterised shift register with fill count, shift-in on valid, pop-oldest, and parallel 48-bit read of the buffered header.
  - The FSM, counters and address compare stay in rx_frame_filter.

Test Plan:
- Unicast match: own_mac=02:00:00:00:00:01, 64-byte frame to that address, 1 byte/2 clk -> 64 out_valid beats in input order; out_last on byte 64; len_data=64; cnt_accept=1.
- Mismatch: 64-byte frame to 02:00:00:00:00:02 -> no out_valid; cnt_drop=1; a following broadcast 60-byte frame is forwarded with len_data=60.
- Runt: 5-byte frame with rx_last on byte 5 -> no output; cnt_drop=1; FSM back in IDLE.
- FIFO full at decision: fifo_full=1 during the 6th byte of a matching frame -> frame dropped, cnt_drop=1. fifo_full=1 for one cycle mid-FWD -> overflow_err=1 and stays 1 until rst.
- Reset mid-frame: rst for 1 clk after 20 forwarded bytes of a 100-byte frame -> all outputs 0 next cycle, no len_valid; the next clean 64-byte matching frame is forwarded, len_data=64.
- Promisc build (RX_FILTER_PROMISC_EN defined): 64-byte frame to 02:00:00:00:00:02 -> forwarded, len_data=64, cnt_accept=1.
